lcd_text_ctrl: RTL and testbench

LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

---
 rtl/lcd_text_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
// HD44780 8-bit text refresher: power-up init, then endless row/char refresh from a host-written buffer.
// Define LCD_CURSOR_EN to turn the cursor and blink on in the display-on command.
module lcd_text_ctrl #(
  parameter int COLS   = 16,
  parameter int ROWS   = 2,
  parameter int T_INIT = 70,
  parameter int E_PW   = 2,
  parameter int T_CMD  = 30,
  parameter int T_CHAR = 20,
  parameter int T_HOLD = 400
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       WR_EN,
  input  logic [1:0] WR_ROW,
  input  logic [5:0] WR_COL,
  input  logic [7:0] WR_CHAR,
  output logic       WR_READY,
  output logic       WR_ERR,
  output logic       INIT_DONE,
  output logic       FRAME_DONE,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  // state    | meaning
  // POWERUP  | wait T_INIT cycles with the bus idle
  // FUNC_SET | command 0x38 (8-bit, 2 lines)
  // DISP_ON  | display on command
  // ENTRY    | entry mode 0x06
  // CLEAR    | clear 0x01, long post-command gap
  // ROW_ADDR | set DDRAM address to start of current row
  // CHARS    | send COLS characters of current row
  // HOLD     | idle T_HOLD cycles between frames

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int T_CLR = 4 * T_CMD;
  localparam int M1    = (T_INIT > T_CLR) ? T_INIT : T_CLR;
  localparam int M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
  localparam int M3    = (M2 > T_CHAR) ? M2 : T_CHAR;
  localparam int MAXC  = (M3 > E_PW) ? M3 : E_PW;
  localparam int CW    = $clog2(MAXC + 1);

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP_CMD = 8'h0F;
`else
  localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

  typedef enum logic [2:0] {
    S_POWERUP, S_FUNC_SET, S_DISP_ON, S_ENTRY, S_CLEAR, S_ROW_ADDR, S_CHARS, S_HOLD
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_EHIGH, P_GAP} phase_t;

  state_t          state, state_d;
  phase_t          phase, phase_d;
  logic [CW-1:0]   cnt, cnt_d, gap_end;
  logic [1:0]      row, row_d;
  logic [5:0]      col, col_d;
  logic [7:0]      buffer [2**AW];
  logic [AW-1:0]   wr_idx, rd_idx;
  logic            wr_ok;
  logic            load, e_d, rs_d, frame_done_d, init_done_d;
  logic [7:0]      data_d;

  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    row_cmd = 8'h80;
      2'd1:    row_cmd = 8'hC0;
      2'd2:    row_cmd = 8'h80 | 8'(COLS);
      default: row_cmd = 8'h80 | (8'h40 + 8'(COLS));
    endcase
  endfunction

  assign wr_ok  = WR_EN && WR_READY && (32'(WR_ROW) < ROWS) && (32'(WR_COL) < COLS);
  assign wr_idx = AW'(32'(WR_ROW) * COLS + 32'(WR_COL));
  assign rd_idx = AW'(32'(row_d) * COLS + 32'(col_d));

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= S_POWERUP;
      phase      <= P_SETUP;
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_RW     <= 1'b0;
      LCD_DATA   <= 8'h00;
      INIT_DONE  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      row        <= row_d;
      col        <= col_d;
      LCD_E      <= e_d;
      LCD_RS     <= rs_d;
      LCD_RW     <= 1'b0;
      LCD_DATA   <= data_d;
      INIT_DONE  <= init_done_d;
      FRAME_DONE <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state;
    phase_d = phase;
    cnt_d   = cnt + 1'b1;
    row_d   = row;
    col_d   = col;
    case (state)
      S_CLEAR: gap_end = CW'(T_CLR - 1);
      S_CHARS: gap_end = CW'(T_CHAR - 1);
      default: gap_end = CW'(T_CMD - 1);
    endcase
    case (state)
      S_POWERUP: if (cnt == CW'(T_INIT - 1)) begin
        state_d = S_FUNC_SET;
        phase_d = P_SETUP;
        cnt_d   = '0;
      end
      S_HOLD: if (cnt == CW'(T_HOLD - 1)) begin
        state_d = S_ROW_ADDR;
        phase_d = P_SETUP;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
      default: begin
        case (phase)
          P_SETUP: begin
            phase_d = P_EHIGH;
            cnt_d   = '0;
          end
          P_EHIGH: if (cnt == CW'(E_PW - 1)) begin
            phase_d = P_GAP;
            cnt_d   = '0;
          end
          default: if (cnt == gap_end) begin
            phase_d = P_SETUP;
            cnt_d   = '0;
            case (state)
              S_FUNC_SET: state_d = S_DISP_ON;
              S_DISP_ON:  state_d = S_ENTRY;
              S_ENTRY:    state_d = S_CLEAR;
              S_CLEAR: begin
                state_d = S_ROW_ADDR;
                row_d   = '0;
              end
              S_ROW_ADDR: begin
                state_d = S_CHARS;
                col_d   = '0;
              end
              S_CHARS: begin
                if (col == 6'(COLS - 1)) begin
                  if (row == 2'(ROWS - 1)) state_d = S_HOLD;
                  else begin
                    state_d = S_ROW_ADDR;
                    row_d   = row + 2'd1;
                  end
                end else begin
                  col_d = col + 6'd1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    endcase
  end

  // Bus registers follow the next state, so RS/DATA are valid from the first setup cycle.
  always_comb begin
    load         = (phase_d == P_SETUP) && (state_d != S_POWERUP) && (state_d != S_HOLD);
    e_d          = (phase_d == P_EHIGH);
    rs_d         = LCD_RS;
    data_d       = LCD_DATA;
    frame_done_d = (state_d == S_HOLD) && (state != S_HOLD);
    init_done_d  = INIT_DONE || (state_d == S_ROW_ADDR);
    if (load) begin
      rs_d = 1'b0;
      case (state_d)
        S_FUNC_SET: data_d = 8'h38;
        S_DISP_ON:  data_d = DISP_CMD;
        S_ENTRY:    data_d = 8'h06;
        S_CLEAR:    data_d = 8'h01;
        S_ROW_ADDR: data_d = row_cmd(row_d);
        S_CHARS: begin
          rs_d   = 1'b1;
          data_d = buffer[rd_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      WR_READY <= 1'b0;
      WR_ERR   <= 1'b0;
      for (int i = 0; i < 2**AW; i++) buffer[i] <= 8'h20;
    end else begin
      WR_READY <= 1'b1;
      WR_ERR   <= WR_EN && WR_READY && !wr_ok;
      if (wr_ok) buffer[wr_idx] <= WR_CHAR;
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: expected bus transactions are queued, a negedge monitor checks them.
module tb_lcd_text_ctrl;
  localparam int COLS = 16, ROWS = 2, T_INIT = 70, E_PW = 2;
  localparam int T_CMD = 30, T_CHAR = 20, T_HOLD = 400;
`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DISP_CMD = 8'h0F;
`else
  localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

  logic       CLK, RESETN, WR_EN;
  logic [1:0] WR_ROW;
  logic [5:0] WR_COL;
  logic [7:0] WR_CHAR;
  logic       WR_READY, WR_ERR, INIT_DONE, FRAME_DONE, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .T_INIT(T_INIT), .E_PW(E_PW), .T_CMD(T_CMD),
                  .T_CHAR(T_CHAR), .T_HOLD(T_HOLD)) dut (
    .CLK(CLK), .RESETN(RESETN), .WR_EN(WR_EN), .WR_ROW(WR_ROW), .WR_COL(WR_COL),
    .WR_CHAR(WR_CHAR), .WR_READY(WR_READY), .WR_ERR(WR_ERR), .INIT_DONE(INIT_DONE),
    .FRAME_DONE(FRAME_DONE), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DATA(LCD_DATA)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       init;
    int         low;
  } txn_t;

  txn_t       q[$];
  txn_t       cur, prev;
  bit         cur_valid = 0, prev_valid = 0, check_first = 0;
  int         n_checks = 0, n_fail = 0, cyc = 0;
  int         rel_cyc = 0, rise_cyc = 0, fall_cyc = 0, frames_seen = 0, frame_txns = 0;
  logic       e_q = 1'b0, fd_q = 1'b0;
  logic [7:0] model [ROWS][COLS];
  logic [7:0] row_cmd [2] = '{8'h80, 8'hC0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input logic init, input int low);
    txn_t t;
    t.rs = rs; t.data = data; t.init = init; t.low = low;
    q.push_back(t);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 1'b0, T_CMD + 1);
    push(1'b0, DISP_CMD, 1'b0, T_CMD + 1);
    push(1'b0, 8'h06, 1'b0, T_CMD + 1);
    push(1'b0, 8'h01, 1'b0, 4 * T_CMD + 1);
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++) begin
      push(1'b0, row_cmd[r], 1'b1, T_CMD + 1);
      for (int c = 0; c < COLS; c++)
        push(1'b1, model[r][c], 1'b1,
             (r == ROWS - 1 && c == COLS - 1) ? T_CHAR + T_HOLD + 1 : T_CHAR + 1);
    end
  endtask

  task automatic wait_frame(input int budget);
    int target = frames_seen + 1;
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (frames_seen < target) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: no FRAME_DONE within %0d cycles", budget);
    end
  endtask

  task automatic host_write(input logic [1:0] r, input logic [5:0] c, input logic [7:0] ch);
    WR_EN = 1'b1; WR_ROW = r; WR_COL = c; WR_CHAR = ch;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (LCD_E && !e_q) begin
      rise_cyc = cyc;
      if (check_first) begin
        check("first_rise_delay", cyc - rel_cyc, T_INIT + 1);
        check_first = 0;
      end else if (prev_valid) begin
        check("low_gap", cyc - fall_cyc, prev.low);
      end
      if (q.size() == 0) begin
        n_checks++; n_fail++; cur_valid = 0;
        $display("FAIL unexpected_txn: rs=%0d data=0x%0h, nothing expected", LCD_RS, LCD_DATA);
      end else begin
        cur = q.pop_front();
        cur_valid = 1;
        check("txn_rs", LCD_RS, cur.rs);
        check("txn_data", LCD_DATA, cur.data);
        check("txn_init_done", INIT_DONE, cur.init);
      end
      check("txn_rw", LCD_RW, 1'b0);
      if (INIT_DONE) frame_txns++;
    end else if (LCD_E && e_q && cur_valid) begin
      check("e_high_data_stable", {LCD_RS, LCD_DATA}, {cur.rs, cur.data});
    end
    if (!LCD_E && e_q && RESETN) begin
      fall_cyc = cyc;
      check("e_width", cyc - rise_cyc, E_PW);
      prev = cur;
      prev_valid = cur_valid;
    end
    if (FRAME_DONE) begin
      check("frame_done_width", fd_q, 1'b0);
      check("frame_txns", frame_txns, ROWS * (COLS + 1));
      check("frame_done_time", cyc - fall_cyc, T_CHAR);
      frame_txns = 0;
      frames_seen++;
    end
    fd_q = FRAME_DONE;
    e_q  = LCD_E;
  end

  initial begin
    int n;
    RESETN = 1'b0; WR_EN = 1'b0; WR_ROW = '0; WR_COL = '0; WR_CHAR = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bus", {LCD_E, LCD_RS, LCD_RW, LCD_DATA}, 11'h000);
    check("rst_flags", {WR_READY, WR_ERR, INIT_DONE, FRAME_DONE}, 4'b0000);

    RESETN = 1'b1; rel_cyc = cyc; check_first = 1; prev_valid = 0;
    push_init();
    @(posedge CLK); #1;
    check("wr_ready_up", WR_READY, 1'b1);
    host_write(2'd1, 6'd15, 8'h41);
    check("wr_err_good", WR_ERR, 1'b0);
    model[1][15] = 8'h41;
    host_write(2'd2, 6'd0, 8'h55);
    check("wr_err_bad_row", WR_ERR, 1'b1);
    @(posedge CLK); #1;
    check("wr_err_one_cycle", WR_ERR, 1'b0);
    host_write(2'd0, 6'd16, 8'h66);
    check("wr_err_bad_col", WR_ERR, 1'b1);
    host_write(2'd0, 6'd0, 8'h48);
    check("wr_err_col0", WR_ERR, 1'b0);
    model[0][0] = 8'h48;
    push_frame();
    wait_frame(3000);
    check("init_done_sticky", INIT_DONE, 1'b1);

    host_write(2'd0, 6'd3, 8'h5A);
    model[0][3] = 8'h5A;
    push_frame();
    wait_frame(3000);
    push_frame();

    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(LCD_E && LCD_RS && frame_txns > 20) && n < 3000);
    check("reach_chars_e_high", {LCD_E, LCD_RS}, 2'b11);
    RESETN = 1'b0;
    @(posedge CLK); #1;
    check("reset_drops_e", LCD_E, 1'b0);
    check("reset_clears_flags", {WR_READY, INIT_DONE}, 2'b00);
    repeat (2) @(posedge CLK);
    #1;
    q.delete();
    prev_valid = 0; cur_valid = 0; frame_txns = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
    RESETN = 1'b1; rel_cyc = cyc; check_first = 1;
    push_init();
    push_frame();
    wait_frame(3000);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
